// File: rtl/mch_rx_frm_ctl_pkg.sv
// mch_rx_frm_ctl_pkg: shared widths, frame packing, FSM states and checksum helper for the frame controller
package mch_rx_frm_ctl_pkg;

    localparam int MCH_MAX_PL = 4;
    localparam int MCH_BYTE_W = 8;
    localparam int FRM_W      = MCH_BYTE_W * (1 + MCH_MAX_PL);

    typedef enum logic {ST_DIS = 1'b0, ST_ARM = 1'b1} state_e;

    // Last payload byte must equal the XOR of the bytes before it; pl is {d0, d1, d2, d3}
    function automatic logic chk_ok(input logic [7:0] len, input logic [MCH_BYTE_W*MCH_MAX_PL-1:0] pl);
        logic [MCH_BYTE_W-1:0] x;
        logic [MCH_BYTE_W-1:0] last;
        logic [MCH_BYTE_W-1:0] b;
        x    = '0;
        last = '0;
        for (int i = 0; i < MCH_MAX_PL; i++) begin
            b = pl[MCH_BYTE_W*(MCH_MAX_PL-i)-1 -: MCH_BYTE_W];
            if (i + 1 < int'(len)) x = x ^ b;
            else if (i + 1 == int'(len)) last = b;
        end
        return x == last;
    endfunction

endpackage

// File: rtl/mch_rx_frm_fifo.sv
// mch_rx_frm_fifo: synchronous frame FIFO with wrap-bit pointers; head reads as zero while empty
module mch_rx_frm_fifo
    import mch_rx_frm_ctl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [FRM_W-1:0] wdata_i,
    output logic [FRM_W-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [FRM_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;

    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    // Storage needs no reset: the head is masked while empty
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

    // Pointer advance; push and pop are already qualified by the caller
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/mch_rx_frm_ctl.sv
// mch_rx_frm_ctl: arms reception, validates frames, buffers them for the host, counts drops and flags link loss.
// Define MCH_RX_CHK_EN to also require an XOR checksum in the last payload byte.
module mch_rx_frm_ctl
    import mch_rx_frm_ctl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_LEN = 4,
    parameter int TMO_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       rcv_done,
    input  logic [7:0] length,
    input  logic [7:0] pd0,
    input  logic [7:0] pd1,
    input  logic [7:0] pd2,
    input  logic [7:0] pd3,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_len,
    output logic [7:0] out_d0,
    output logic [7:0] out_d1,
    output logic [7:0] out_d2,
    output logic [7:0] out_d3,
    output logic [7:0] ovf_cnt,
    output logic [7:0] err_cnt,
    output logic       link_lost,
    input  logic       clr_cnt
);

    localparam int            TW      = $clog2(TMO_CYC);
    localparam logic [TW-1:0] TMO_MAX = TW'(TMO_CYC - 1);

    state_e           state_q;
    logic             rcv_done_q;
    logic [TW-1:0]    tmo_q;
    logic [TW-1:0]    tmo_d;
    logic             lost_q;
    logic             lost_d;
    logic [7:0]       ovf_q;
    logic [7:0]       err_q;
    logic             arm;
    logic             done_rise;
    logic             len_bad;
    logic             chk_bad;
    logic             frm_ok;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [FRM_W-1:0] head;

    assign arm       = state_q == ST_ARM;
    assign done_rise = rcv_done & ~rcv_done_q;
    assign len_bad   = length == 8'd0 || length > 8'(MAX_LEN);
`ifdef MCH_RX_CHK_EN
    assign chk_bad   = ~len_bad & ~chk_ok(length, {pd0, pd1, pd2, pd3});
`else
    assign chk_bad   = 1'b0;
`endif
    assign frm_ok    = arm & done_rise & ~len_bad & ~chk_bad;
    assign pop       = ~empty & out_ready;
    assign push      = frm_ok & (~full | pop);

    // Timeout counter parks at its terminal value; a written frame or disarm restarts it
    assign tmo_d  = (!arm || push) ? '0 : (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
    assign lost_d = (!arm || push) ? 1'b0 : lost_q | (tmo_d == TMO_MAX);

    // Arm/disarm FSM, rcv_done edge register and link-loss tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_DIS;
            rcv_done_q <= 1'b0;
            tmo_q      <= '0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= rx_en ? ST_ARM : ST_DIS;
            rcv_done_q <= rcv_done;
            tmo_q      <= tmo_d;
            lost_q     <= lost_d;
        end
    end

    // Saturating drop counters; clear has priority over a same-cycle increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= '0;
            err_q <= '0;
        end else begin
            ovf_q <= clr_cnt ? '0 : (frm_ok && !push && ovf_q != 8'hFF) ? ovf_q + 1'b1 : ovf_q;
            err_q <= clr_cnt ? '0 : (arm && done_rise && (len_bad || chk_bad) && err_q != 8'hFF) ? err_q + 1'b1 : err_q;
        end
    end

    mch_rx_frm_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({length, pd0, pd1, pd2, pd3}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign out_valid = ~empty;
    assign {out_len, out_d0, out_d1, out_d2, out_d3} = head;
    assign ovf_cnt   = ovf_q;
    assign err_cnt   = err_q;
    assign link_lost = lost_q;

endmodule

// File: tb/tb_mch_rx_frm_ctl.sv
// tb_mch_rx_frm_ctl: directed stimulus with a frame scoreboard checked by an independent output monitor
module tb_mch_rx_frm_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_en = 1'b0;
    logic       rcv_done = 1'b0;
    logic [7:0] length = '0;
    logic [7:0] pd0 = '0, pd1 = '0, pd2 = '0, pd3 = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_len, out_d0, out_d1, out_d2, out_d3;
    logic [7:0] ovf_cnt, err_cnt;
    logic       link_lost;
    logic       clr_cnt = 1'b0;

    int         checks = 0;
    int         errors = 0;
    logic [39:0] sb[$];
    logic [39:0] head;

    mch_rx_frm_ctl #(.DEPTH(4), .MAX_LEN(4), .TMO_CYC(16)) dut (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rcv_done(rcv_done), .length(length),
        .pd0(pd0), .pd1(pd1), .pd2(pd2), .pd3(pd3),
        .out_valid(out_valid), .out_ready(out_ready), .out_len(out_len),
        .out_d0(out_d0), .out_d1(out_d1), .out_d2(out_d2), .out_d3(out_d3),
        .ovf_cnt(ovf_cnt), .err_cnt(err_cnt), .link_lost(link_lost), .clr_cnt(clr_cnt)
    );

    always #5 clk = ~clk;

    assign head = {out_len, out_d0, out_d1, out_d2, out_d3};

    // Monitor: on the falling edge compare the presented head with the scoreboard, pop on handshake
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame got %h want no frame", head);
                end else begin
                    if (head !== sb[0]) begin
                        errors++;
                        $display("FAIL head_frame got %h want %h", head, sb[0]);
                    end
                    if (out_ready) void'(sb.pop_front());
                end
            end else if (head !== 40'd0) begin
                errors++;
                $display("FAIL empty_head got %h want 0", head);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic send(input logic [7:0] l, input logic [31:0] p, input bit exp);
        length = l;
        {pd0, pd1, pd2, pd3} = p;
        rcv_done = 1'b1;
        if (exp) sb.push_back({l, p});
        tick(1);
        rcv_done = 1'b0;
        tick(1);
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        tick(n);
        out_ready = 1'b0;
        chk("drained", 32'(sb.size()), 32'd0);
        chk("drained_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        tick(3);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(ovf_cnt), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_lost", 32'(link_lost), 32'd0);
        rst = 1'b1;
        tick(1);
        rx_en = 1'b1;
        tick(1);
        // basic frame, visible one clock after the done edge
        length = 8'd3;
        {pd0, pd1, pd2, pd3} = 32'h11223300;
        rcv_done = 1'b1;
        sb.push_back(40'h03_11223300);
        tick(1);
        chk("valid_latency", 32'(out_valid), 32'd1);
        rcv_done = 1'b0;
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("pop_clears", 32'(out_valid), 32'd0);
        // bad lengths
        send(8'd0, 32'hAABBCCDD, 1'b0);
        send(8'd5, 32'h01020304, 1'b0);
        chk("bad_len_err", 32'(err_cnt), 32'd2);
        chk("bad_len_valid", 32'(out_valid), 32'd0);
        // overflow: four buffered, fifth dropped
        send(8'd1, 32'hA1000000, 1'b1);
        send(8'd2, 32'hB1B20000, 1'b1);
        send(8'd4, 32'hC1C2C3C4, 1'b1);
        send(8'd3, 32'hD1D2D300, 1'b1);
        send(8'd4, 32'hE1E2E3E4, 1'b0);
        chk("ovf_one", 32'(ovf_cnt), 32'd1);
        chk("ovf_err_same", 32'(err_cnt), 32'd2);
        // push into full FIFO while popping is accepted
        length = 8'd2;
        {pd0, pd1, pd2, pd3} = 32'hF1F20000;
        rcv_done = 1'b1;
        out_ready = 1'b1;
        sb.push_back(40'h02_F1F20000);
        tick(1);
        out_ready = 1'b0;
        rcv_done = 1'b0;
        tick(1);
        chk("ovf_full_pop", 32'(ovf_cnt), 32'd1);
        drain(5);
        // level rcv_done yields one frame
        length = 8'd4;
        {pd0, pd1, pd2, pd3} = 32'h5A5B5C5D;
        rcv_done = 1'b1;
        sb.push_back(40'h04_5A5B5C5D);
        tick(10);
        rcv_done = 1'b0;
        tick(1);
        drain(3);
        chk("level_err", 32'(err_cnt), 32'd2);
        chk("level_ovf", 32'(ovf_cnt), 32'd1);
        // disarm keeps buffered frame, ignores new ones
        send(8'd1, 32'h77000000, 1'b1);
        rx_en = 1'b0;
        tick(2);
        send(8'd2, 32'h12340000, 1'b0);
        send(8'd0, 32'h0, 1'b0);
        chk("dis_keep_valid", 32'(out_valid), 32'd1);
        chk("dis_err", 32'(err_cnt), 32'd2);
        chk("dis_lost", 32'(link_lost), 32'd0);
        drain(2);
        // timeout
        rx_en = 1'b1;
        tick(15);
        chk("tmo_before", 32'(link_lost), 32'd0);
        tick(1);
        chk("tmo_at", 32'(link_lost), 32'd1);
        length = 8'd1;
        {pd0, pd1, pd2, pd3} = 32'h00000000;
        rcv_done = 1'b1;
        sb.push_back(40'h01_00000000);
        tick(1);
        chk("tmo_clear", 32'(link_lost), 32'd0);
        rcv_done = 1'b0;
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(16);
        chk("tmo_again", 32'(link_lost), 32'd1);
        send(8'd0, 32'h0, 1'b0);
        chk("tmo_drop_sticky", 32'(link_lost), 32'd1);
        // saturation and clear
        for (int i = 0; i < 260; i++) send(8'd9, 32'h0, 1'b0);
        chk("err_sat", 32'(err_cnt), 32'd255);
        length = 8'd0;
        rcv_done = 1'b1;
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
        rcv_done = 1'b0;
        chk("clr_err", 32'(err_cnt), 32'd0);
        chk("clr_ovf", 32'(ovf_cnt), 32'd0);
        tick(1);
`ifdef MCH_RX_CHK_EN
        send(8'd3, 32'h0FF0FF00, 1'b1);
        send(8'd3, 32'h0FF0FE00, 1'b0);
        chk("chk_err", 32'(err_cnt), 32'd1);
        drain(2);
`endif
        tick(2);
        chk("final_sb", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
